// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control sequencer:
// opcode and ALU-op constants, the sequencer state enum, the control
// strobe bundle, immediate extractors and the legality check.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // {op_en, mod, funct3}; op_en=0 means "latch operand A"
  localparam logic [4:0] ALU_LOAD_A = 5'b00000;
  localparam logic [4:0] ALU_ADD    = 5'b10000;
  localparam logic [4:0] ALU_SUB    = 5'b11000;
  localparam logic [4:0] ALU_SLT    = 5'b10010;
  localparam logic [4:0] ALU_SLTU   = 5'b10011;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_TRAP} state_e;

  typedef struct packed {
    logic mem_load;
    logic mem_rd;
    logic mem_wr;
    logic pc_rd;
    logic pc_wr;
    logic pc_inc;
    logic reg_rd;
    logic reg_wr;
    logic alu_wr;
    logic alu_rd;
    logic bus_out_en;
  } strobes_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic is_legal(input logic [31:0] ir);
    logic ok;
    case (ir[6:0])
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
      OPC_LOAD, OPC_STORE: ok = (ir[14:12] == 3'b010);
      OPC_JALR:            ok = (ir[14:12] == 3'b000);
      OPC_BRANCH:          ok = (ir[14:13] != 2'b01);
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microsequence decoder for the EXEC state.
// Inputs : ir (latched instruction), step, alu_flag, mem_ready.
// Outputs: strobe bundle, reg_addr, alu_op, bus_out, drive_tmp (bus_out
//          must come from the JALR target register), tmp_load, last
//          (instruction completes this cycle), stall, illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALU_OPW = 5,
  parameter int unsigned STEP_W  = 3
) (
  input  logic [31:0]        ir,
  input  logic [STEP_W-1:0]  step,
  input  logic               alu_flag,
  input  logic               mem_ready,
  output strobes_t           stb,
  output logic [REG_AW-1:0]  reg_addr,
  output logic [ALU_OPW-1:0] alu_op,
  output logic [XLEN-1:0]    bus_out,
  output logic               drive_tmp,
  output logic               tmp_load,
  output logic               last,
  output logic               stall,
  output logic               illegal
);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [7:0]        sn;
  logic              mod, taken, mem_step;
  logic [4:0]        cmp_op;

  assign opc     = ir[6:0];
  assign f3      = ir[14:12];
  assign rd      = REG_AW'(ir[11:7]);
  assign rs1     = REG_AW'(ir[19:15]);
  assign rs2     = REG_AW'(ir[24:20]);
  assign sn      = 8'(step);
  assign illegal = !is_legal(ir);
  // funct7[5] only modifies OP-IMM for the shift encodings
  assign mod     = (opc == OPC_OP) ? ir[30] : ((f3[1:0] == 2'b01) ? ir[30] : 1'b0);
  // BEQ, BGE, BGEU branch when the compare result is zero
  assign taken   = alu_flag ^ ((f3 == 3'b000) | (f3[2] & f3[0]));
  assign cmp_op  = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);

  always_comb begin
    stb       = '0;
    reg_addr  = '0;
    alu_op    = '0;
    bus_out   = '0;
    drive_tmp = 1'b0;
    tmp_load  = 1'b0;
    last      = 1'b0;
    mem_step  = 1'b0;
    case (opc)
      OPC_OP_IMM, OPC_OP, OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JALR: begin
        case (sn)
          8'd0: begin
            stb.alu_wr = 1'b1;
            if (opc == OPC_OP) begin
              stb.reg_rd = 1'b1;
              reg_addr   = rs2;
            end else begin
              stb.bus_out_en = 1'b1;
              bus_out = (opc == OPC_AUIPC) ? XLEN'(imm_u(ir)) :
                        (opc == OPC_STORE) ? XLEN'(imm_s(ir)) : XLEN'(imm_i(ir));
            end
          end
          8'd1: begin
            stb.alu_wr = 1'b1;
            alu_op     = ALU_OPW'(ALU_ADD);
            if (opc == OPC_AUIPC) begin
              stb.pc_rd = 1'b1;
            end else begin
              stb.reg_rd = 1'b1;
              reg_addr   = rs1;
              if (opc == OPC_OP_IMM || opc == OPC_OP) alu_op = ALU_OPW'({1'b1, mod, f3});
            end
          end
          8'd2: begin
            stb.alu_rd = 1'b1;
            if (opc == OPC_LOAD || opc == OPC_STORE) begin
              stb.mem_load = 1'b1;
            end else if (opc == OPC_JALR) begin
              tmp_load = 1'b1;
            end else begin
              stb.reg_wr = 1'b1;
              reg_addr   = rd;
              stb.pc_inc = 1'b1;
              last       = 1'b1;
            end
          end
          8'd3: begin
            mem_step   = 1'b1;
            stb.pc_inc = 1'b1;
            last       = 1'b1;
            if (opc == OPC_LOAD) begin
              stb.mem_rd = 1'b1;
              stb.reg_wr = 1'b1;
              reg_addr   = rd;
            end else if (opc == OPC_STORE) begin
              stb.mem_wr = 1'b1;
              stb.reg_rd = 1'b1;
              reg_addr   = rs2;
            end else begin
              // JALR: start of the link sequence, not a memory step
              mem_step   = 1'b0;
              stb.pc_inc = 1'b0;
              last       = 1'b0;
              stb.pc_rd  = 1'b1;
              stb.alu_wr = 1'b1;
            end
          end
          8'd4: begin
            stb.bus_out_en = 1'b1;
            bus_out        = XLEN'(4);
            stb.alu_wr     = 1'b1;
            alu_op         = ALU_OPW'(ALU_ADD);
          end
          8'd5: begin
            stb.alu_rd = 1'b1;
            stb.reg_wr = 1'b1;
            reg_addr   = rd;
          end
          8'd6: begin
            stb.bus_out_en = 1'b1;
            drive_tmp      = 1'b1;
            stb.pc_wr      = 1'b1;
            last           = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        stb.bus_out_en = 1'b1;
        bus_out        = XLEN'(imm_u(ir));
        stb.reg_wr     = 1'b1;
        reg_addr       = rd;
        stb.pc_inc     = 1'b1;
        last           = 1'b1;
      end
      OPC_BRANCH: begin
        case (sn)
          8'd0: begin
            stb.reg_rd = 1'b1;
            reg_addr   = rs2;
            stb.alu_wr = 1'b1;
          end
          8'd1: begin
            stb.reg_rd = 1'b1;
            reg_addr   = rs1;
            stb.alu_wr = 1'b1;
            alu_op     = ALU_OPW'(cmp_op);
          end
          8'd2: begin
            if (taken) begin
              stb.bus_out_en = 1'b1;
              bus_out        = XLEN'(imm_b(ir));
              stb.alu_wr     = 1'b1;
            end else begin
              stb.pc_inc = 1'b1;
              last       = 1'b1;
            end
          end
          8'd3: begin
            stb.pc_rd  = 1'b1;
            stb.alu_wr = 1'b1;
            alu_op     = ALU_OPW'(ALU_ADD);
          end
          8'd4: begin
            stb.alu_rd = 1'b1;
            stb.pc_wr  = 1'b1;
            last       = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_JAL: begin
        case (sn)
          8'd0, 8'd4: begin
            stb.pc_rd  = 1'b1;
            stb.alu_wr = 1'b1;
            alu_op     = (sn == 8'd4) ? ALU_OPW'(ALU_ADD) : '0;
          end
          8'd1: begin
            stb.bus_out_en = 1'b1;
            bus_out        = XLEN'(4);
            stb.alu_wr     = 1'b1;
            alu_op         = ALU_OPW'(ALU_ADD);
          end
          8'd2: begin
            stb.alu_rd = 1'b1;
            stb.reg_wr = 1'b1;
            reg_addr   = rd;
          end
          8'd3: begin
            stb.bus_out_en = 1'b1;
            bus_out        = XLEN'(imm_j(ir));
            stb.alu_wr     = 1'b1;
          end
          8'd5: begin
            stb.alu_rd = 1'b1;
            stb.pc_wr  = 1'b1;
            last       = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // A stalled memory step keeps its strobes but must not complete
    stall = mem_step & ~mem_ready;
    if (stall) begin
      stb.pc_inc = 1'b0;
      last       = 1'b0;
    end
  end

endmodule

// File: rtl/control_seq.sv
// Multi-cycle control sequencer for the shared-bus RV32I core.
// Holds the FETCH/EXEC/TRAP FSM, the per-instruction step counter, the
// instruction register and the JALR target register; EXEC strobes come
// from ctrl_decode. All outputs are forced to 0 while rst_n is low.
// Ports: clk, rst_n; bus_in/bus_out/bus_out_en (shared bus); mem_ready,
// alu_flag (status in); mem_*, pc_*, reg_*, alu_* strobes, reg_addr,
// alu_op; trap (sticky illegal instruction), retire (final-step pulse).
module control_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALU_OPW = 5,
  parameter int unsigned STEP_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    bus_in,
  output logic [XLEN-1:0]    bus_out,
  output logic               bus_out_en,
  input  logic               mem_ready,
  input  logic               alu_flag,
  output logic               mem_load,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               pc_rd,
  output logic               pc_wr,
  output logic               pc_inc,
  output logic               reg_rd,
  output logic               reg_wr,
  output logic [REG_AW-1:0]  reg_addr,
  output logic               alu_wr,
  output logic               alu_rd,
  output logic [ALU_OPW-1:0] alu_op,
  output logic               trap,
  output logic               retire
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [31:0]         ir_q, ir_d;
  logic [XLEN-1:0]     tmp_q, tmp_d;

  strobes_t            dec_stb, stb;
  logic [REG_AW-1:0]   dec_addr, addr_c;
  logic [ALU_OPW-1:0]  dec_op, op_c;
  logic [XLEN-1:0]     dec_bus, bus_c;
  logic                dec_tmp, dec_tmp_load, dec_last, dec_stall, dec_illegal;
  logic                trap_c, retire_c;

  ctrl_decode #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .ALU_OPW (ALU_OPW),
    .STEP_W  (STEP_W)
  ) u_decode (
    .ir        (ir_q),
    .step      (step_q),
    .alu_flag  (alu_flag),
    .mem_ready (mem_ready),
    .stb       (dec_stb),
    .reg_addr  (dec_addr),
    .alu_op    (dec_op),
    .bus_out   (dec_bus),
    .drive_tmp (dec_tmp),
    .tmp_load  (dec_tmp_load),
    .last      (dec_last),
    .stall     (dec_stall),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      step_q  <= '0;
      ir_q    <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ir_q    <= ir_d;
      tmp_q   <= tmp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ir_d     = ir_q;
    tmp_d    = tmp_q;
    stb      = '0;
    addr_c   = '0;
    op_c     = '0;
    bus_c    = '0;
    trap_c   = 1'b0;
    retire_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (step_q == '0) begin
          stb.pc_rd    = 1'b1;
          stb.mem_load = 1'b1;
          step_d       = STEP_W'(1);
        end else begin
          stb.mem_rd = 1'b1;
          if (mem_ready) begin
            ir_d    = bus_in[31:0];
            step_d  = '0;
            state_d = is_legal(bus_in[31:0]) ? ST_EXEC : ST_TRAP;
          end
        end
      end
      ST_EXEC: begin
        if (dec_illegal) begin
          state_d = ST_TRAP;
          step_d  = '0;
        end else begin
          stb      = dec_stb;
          addr_c   = dec_addr;
          op_c     = dec_op;
          bus_c    = dec_tmp ? tmp_q : dec_bus;
          retire_c = dec_last;
          if (dec_tmp_load) tmp_d = {bus_in[XLEN-1:1], 1'b0};
          if (dec_last) begin
            state_d = ST_FETCH;
            step_d  = '0;
          end else if (!dec_stall) begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      ST_TRAP: trap_c = 1'b1;
      default: begin
        state_d = ST_FETCH;
        step_d  = '0;
      end
    endcase
  end

  assign bus_out    = rst_n ? bus_c  : '0;
  assign reg_addr   = rst_n ? addr_c : '0;
  assign alu_op     = rst_n ? op_c   : '0;
  assign bus_out_en = rst_n & stb.bus_out_en;
  assign mem_load   = rst_n & stb.mem_load;
  assign mem_rd     = rst_n & stb.mem_rd;
  assign mem_wr     = rst_n & stb.mem_wr;
  assign pc_rd      = rst_n & stb.pc_rd;
  assign pc_wr      = rst_n & stb.pc_wr;
  assign pc_inc     = rst_n & stb.pc_inc;
  assign reg_rd     = rst_n & stb.reg_rd;
  assign reg_wr     = rst_n & stb.reg_wr;
  assign alu_wr     = rst_n & stb.alu_wr;
  assign alu_rd     = rst_n & stb.alu_rd;
  assign trap       = rst_n & trap_c;
  assign retire     = rst_n & retire_c;

endmodule

// File: tb/tb_control_seq.sv
// Randomized bench for control_seq: instructions are assembled from random
// fields, and the expected per-cycle strobe pattern is built from the ISA
// microsequence description as a queue of steps.
module tb_control_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_in, bus_out;
  logic        bus_out_en, mem_ready, alu_flag;
  logic        mem_load, mem_rd, mem_wr, pc_rd, pc_wr, pc_inc;
  logic        reg_rd, reg_wr, alu_wr, alu_rd, trap, retire;
  logic [4:0]  reg_addr, alu_op;

  always #5 clk = ~clk;

  control_seq #(.XLEN(32), .REG_AW(5), .ALU_OPW(5), .STEP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_out(bus_out),
    .bus_out_en(bus_out_en), .mem_ready(mem_ready), .alu_flag(alu_flag),
    .mem_load(mem_load), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_rd(pc_rd),
    .pc_wr(pc_wr), .pc_inc(pc_inc), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_op(alu_op),
    .trap(trap), .retire(retire)
  );

  localparam logic [4:0] OP_A = 5'b00000, OP_ADD = 5'b10000, OP_SUB = 5'b11000,
                         OP_SLT = 5'b10010, OP_SLTU = 5'b10011;

  typedef struct packed {
    logic [31:0] bus;
    logic en, mld, mrd, mwr, prd, pwr, pinc, rrd, rwr;
    logic [4:0] ra;
    logic awr, ard;
    logic [4:0] aop;
    logic trap, ret;
  } obs_t;

  typedef struct {
    obs_t        e;
    bit          stall;
    int          nwait;
    logic [31:0] bus_in;
    logic        flag;
  } step_t;

  step_t       q[$];
  int unsigned n_vec = 0, n_bad = 0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.bus = bus_out;  o.en = bus_out_en; o.mld = mem_load; o.mrd = mem_rd;
    o.mwr = mem_wr;   o.prd = pc_rd;     o.pwr = pc_wr;    o.pinc = pc_inc;
    o.rrd = reg_rd;   o.rwr = reg_wr;    o.ra = reg_addr;  o.awr = alu_wr;
    o.ard = alu_rd;   o.aop = alu_op;    o.trap = trap;    o.ret = retire;
    return o;
  endfunction

  // expectation builders
  function automatic obs_t a_imm(input logic [31:0] v);
    obs_t e = '0; e.bus = v; e.en = 1'b1; e.awr = 1'b1; return e;
  endfunction
  function automatic obs_t a_reg(input logic [4:0] r, input logic [4:0] op);
    obs_t e = '0; e.rrd = 1'b1; e.ra = r; e.awr = 1'b1; e.aop = op; return e;
  endfunction
  function automatic obs_t a_pc(input logic [4:0] op);
    obs_t e = '0; e.prd = 1'b1; e.awr = 1'b1; e.aop = op; return e;
  endfunction
  function automatic obs_t a_four();
    obs_t e = '0; e.bus = 32'd4; e.en = 1'b1; e.awr = 1'b1; e.aop = OP_ADD; return e;
  endfunction
  function automatic obs_t wb(input logic [4:0] rd, input bit fin);
    obs_t e = '0; e.ard = 1'b1; e.rwr = 1'b1; e.ra = rd; e.pinc = fin; e.ret = fin; return e;
  endfunction
  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  task automatic push(input obs_t e, input bit stall);
    step_t s;
    s.e = e; s.stall = stall; s.nwait = -1;
    s.bus_in = $urandom; s.flag = 1'($urandom);
    q.push_back(s);
  endtask

  task automatic cycle(input string tag, input obs_t e, input logic rdy,
                       input logic fl, input logic [31:0] bi);
    mem_ready = rdy; alu_flag = fl; bus_in = bi;
    @(negedge clk);
    check_vec(tag, 64'(observe()), 64'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(input string tag);
    step_t s;
    obs_t  w;
    int    n;
    while (q.size() > 0) begin
      s = q.pop_front();
      if (s.stall) begin
        n = (s.nwait < 0) ? int'($urandom_range(0, 3)) : s.nwait;
        w = s.e; w.pinc = 1'b0; w.ret = 1'b0;
        for (int i = 0; i < n; i++) cycle({tag, "_stall"}, w, 1'b0, s.flag, $urandom);
        cycle(tag, s.e, 1'b1, s.flag, s.bus_in);
      end else begin
        cycle(tag, s.e, 1'($urandom), s.flag, s.bus_in);
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1 check_vec(tag, 64'(observe()), 64'(0));
    #1 rst_n = 1'b1;
  endtask

  task automatic add_fetch(input logic [31:0] instr, input int nwait);
    obs_t e;
    e = '0; e.prd = 1'b1; e.mld = 1'b1; push(e, 1'b0);
    e = '0; e.mrd = 1'b1; push(e, 1'b1);
    q[q.size()-1].bus_in = instr;
    q[q.size()-1].nwait  = nwait;
  endtask

  task automatic do_opimm(input logic [4:0] rd, rs1, input logic [2:0] f3, input logic [11:0] im);
    logic mod = (f3 == 3'd1 || f3 == 3'd5) ? im[10] : 1'b0;
    add_fetch({im, rs1, f3, rd, 7'b0010011}, -1);
    push(a_imm(sx12(im)), 1'b0);
    push(a_reg(rs1, {1'b1, mod, f3}), 1'b0);
    push(wb(rd, 1'b1), 1'b0);
    run_q("opimm");
  endtask

  task automatic do_op(input logic [4:0] rd, rs1, rs2, input logic [2:0] f3, input logic alt);
    add_fetch({1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011}, -1);
    push(a_reg(rs2, OP_A), 1'b0);
    push(a_reg(rs1, {1'b1, alt, f3}), 1'b0);
    push(wb(rd, 1'b1), 1'b0);
    run_q("op");
  endtask

  task automatic do_upper(input bit auipc, input logic [4:0] rd, input logic [19:0] u);
    obs_t e;
    add_fetch({u, rd, auipc ? 7'b0010111 : 7'b0110111}, -1);
    if (auipc) begin
      push(a_imm({u, 12'b0}), 1'b0);
      push(a_pc(OP_ADD), 1'b0);
      push(wb(rd, 1'b1), 1'b0);
    end else begin
      e = '0; e.bus = {u, 12'b0}; e.en = 1'b1; e.rwr = 1'b1; e.ra = rd;
      e.pinc = 1'b1; e.ret = 1'b1;
      push(e, 1'b0);
    end
    run_q(auipc ? "auipc" : "lui");
  endtask

  task automatic do_mem(input bit store, input logic [4:0] rdrs2, rs1,
                        input logic [11:0] im, input int nwait, input bit abort);
    obs_t  e;
    step_t s;
    if (store) add_fetch({im[11:5], rdrs2, rs1, 3'b010, im[4:0], 7'b0100011}, -1);
    else       add_fetch({im, rs1, 3'b010, rdrs2, 7'b0000011}, -1);
    push(a_imm(sx12(im)), 1'b0);
    push(a_reg(rs1, OP_ADD), 1'b0);
    e = '0; e.ard = 1'b1; e.mld = 1'b1; push(e, 1'b0);
    e = '0; e.ra = rdrs2; e.pinc = 1'b1; e.ret = 1'b1;
    if (store) begin e.rrd = 1'b1; e.mwr = 1'b1; end
    else       begin e.mrd = 1'b1; e.rwr = 1'b1; end
    push(e, 1'b1);
    q[q.size()-1].nwait = nwait;
    if (abort) begin
      s = q.pop_back();
      run_q("sw_pre");
      e = s.e; e.pinc = 1'b0; e.ret = 1'b0;
      for (int i = 0; i < 2; i++) cycle("sw_stall", e, 1'b0, 1'($urandom), $urandom);
      pulse_reset("sw_abort");
    end else begin
      run_q(store ? "sw" : "lw");
    end
  endtask

  task automatic do_br(input logic [2:0] f3, input logic [4:0] rs1, rs2,
                       input logic [12:0] b, input logic flag);
    obs_t e;
    logic taken;
    logic [4:0] cmp;
    case (f3)
      3'd0:    begin cmp = OP_SUB;  taken = !flag; end
      3'd1:    begin cmp = OP_SUB;  taken = flag;  end
      3'd4:    begin cmp = OP_SLT;  taken = flag;  end
      3'd5:    begin cmp = OP_SLT;  taken = !flag; end
      3'd6:    begin cmp = OP_SLTU; taken = flag;  end
      default: begin cmp = OP_SLTU; taken = !flag; end
    endcase
    add_fetch({b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011}, -1);
    push(a_reg(rs2, OP_A), 1'b0);
    push(a_reg(rs1, cmp), 1'b0);
    if (taken) begin
      push(a_imm({{19{b[12]}}, b}), 1'b0);
      q[q.size()-1].flag = flag;
      push(a_pc(OP_ADD), 1'b0);
      e = '0; e.ard = 1'b1; e.pwr = 1'b1; e.ret = 1'b1; push(e, 1'b0);
    end else begin
      e = '0; e.pinc = 1'b1; e.ret = 1'b1; push(e, 1'b0);
      q[q.size()-1].flag = flag;
    end
    run_q(taken ? "br_taken" : "br_not");
  endtask

  task automatic do_jal(input logic [4:0] rd, input logic [20:0] j);
    obs_t e;
    add_fetch({j[20], j[10:1], j[11], j[19:12], rd, 7'b1101111}, -1);
    push(a_pc(OP_A), 1'b0);
    push(a_four(), 1'b0);
    push(wb(rd, 1'b0), 1'b0);
    push(a_imm({{11{j[20]}}, j}), 1'b0);
    push(a_pc(OP_ADD), 1'b0);
    e = '0; e.ard = 1'b1; e.pwr = 1'b1; e.ret = 1'b1; push(e, 1'b0);
    run_q("jal");
  endtask

  task automatic do_jalr(input logic [4:0] rd, rs1, input logic [11:0] im, input logic [31:0] tgt);
    obs_t e;
    add_fetch({im, rs1, 3'b000, rd, 7'b1100111}, -1);
    push(a_imm(sx12(im)), 1'b0);
    push(a_reg(rs1, OP_ADD), 1'b0);
    e = '0; e.ard = 1'b1; push(e, 1'b0);
    q[q.size()-1].bus_in = tgt;
    push(a_pc(OP_A), 1'b0);
    push(a_four(), 1'b0);
    push(wb(rd, 1'b0), 1'b0);
    e = '0; e.bus = {tgt[31:1], 1'b0}; e.en = 1'b1; e.pwr = 1'b1; e.ret = 1'b1;
    push(e, 1'b0);
    run_q("jalr");
  endtask

  task automatic do_trap(input logic [31:0] instr);
    obs_t e;
    add_fetch(instr, -1);
    run_q("trap_fetch");
    e = '0; e.trap = 1'b1;
    for (int i = 0; i < 20; i++) cycle("trap_hold", e, 1'($urandom), 1'($urandom), $urandom);
    pulse_reset("trap_reset");
  endtask

  task automatic rand_illegal();
    case ($urandom_range(0, 3))
      0: do_trap(32'hFFFF_FFFF);
      1: do_trap({17'($urandom), 3'b011, 5'($urandom), 7'b0000011});
      2: do_trap({17'($urandom), 3'b010, 5'($urandom), 7'b1100011});
      default: do_trap({17'($urandom), 3'b001, 5'($urandom), 7'b1100111});
    endcase
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; alu_flag = 1'b1; bus_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 check_vec("reset", 64'(observe()), 64'(0));
    #1 rst_n = 1'b1;

    do_opimm(5'd5, 5'd0, 3'd0, 12'hFFD);              // ADDI x5,x0,-3
    do_mem(1'b0, 5'd1, 5'd2, 12'd8, 3, 1'b0);         // LW x1,8(x2), 3 wait cycles
    do_br(3'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1);          // BEQ not taken
    do_br(3'd0, 5'd1, 5'd2, 13'h1FF8, 1'b0);          // BEQ taken, imm -8
    do_jalr(5'd3, 5'd3, 12'd5, 32'h0000_0105);        // JALR x3,x3,5
    do_trap(32'hFFFF_FFFF);
    do_mem(1'b1, 5'd7, 5'd9, 12'h123, -1, 1'b1);      // SW aborted by reset mid-stall

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 10))
        0: do_opimm(5'($urandom), 5'($urandom), 3'($urandom), 12'($urandom));
        1: do_op(5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom));
        2: do_upper(1'b0, 5'($urandom), 20'($urandom));
        3: do_upper(1'b1, 5'($urandom), 20'($urandom));
        4: do_mem(1'b0, 5'($urandom), 5'($urandom), 12'($urandom), -1, 1'b0);
        5: do_mem(1'b1, 5'($urandom), 5'($urandom), 12'($urandom), -1, 1'b0);
        6, 7: begin
          logic [2:0] f3;
          f3 = 3'($urandom);
          if (f3[2:1] == 2'b01) f3[1] = 1'b0;
          do_br(f3, 5'($urandom), 5'($urandom), {12'($urandom), 1'b0}, 1'($urandom));
        end
        8: do_jal(5'($urandom), {20'($urandom), 1'b0});
        9: do_jalr(5'($urandom), 5'($urandom), 12'($urandom), $urandom);
        default: if ($urandom_range(0, 3) == 0) rand_illegal();
                 else do_mem(1'b1, 5'($urandom), 5'($urandom), 12'($urandom), -1, 1'b1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised multi-cycle control sequencer for the shared-bus RV32I core; successor to the fixed 10-step counter control unit.
- Explicit FSM plus a variable-length step counter, so each instruction takes only the steps it needs.
- Memory steps stall on a ready handshake.
- Adds proper OP, AUIPC, branches, JAL and JALR, and a sticky illegal-instruction trap.
- Drives the PC, register file, ALU and memory strobes; the top level owns the bus tristate.

Parameters:
XLEN, 32, datapath and bus width
REG_AW, 5, register address width
ALU_OPW, 5, ALU opcode width; encoding is {op_en, mod, funct3}, and 0 means "latch operand A"
STEP_W, 3, width of the per-instruction step counter

Ports:
clk  in  1  core clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
bus_in  in  XLEN  sampled bus value
bus_out  out  XLEN  value this block drives onto the bus
bus_out_en  out  1  enable for bus_out at the top-level tristate
mem_ready  in  1  memory has completed the current mem_rd or mem_wr
alu_flag  in  1  registered ALU result is nonzero
mem_load, mem_rd, mem_wr  out  1 each  memory address-load / read / write strobes
pc_rd, pc_wr, pc_inc  out  1 each  PC drive / load / +4
reg_rd, reg_wr  out  1 each  register file drive / write
reg_addr  out  REG_AW  register file address
alu_wr, alu_rd  out  1 each  ALU latch / drive result
alu_op  out  ALU_OPW  ALU operation
trap  out  1  sticky illegal-instruction flag
retire  out  1  one-cycle pulse on an instruction's final step

Behaviour:
Reset and output timing
- States: FETCH, EXEC, TRAP.
- Registers: ir, tmp, step.
- rst_n low, asynchronously: state=FETCH, step=0, ir=0, tmp=0.
- All outputs are a combinational decode of (state, step, ir) and are 0 during reset.
- Defaults every cycle: all strobes 0, reg_addr=0, alu_op=0, bus_out=0, bus_out_en=0.

FETCH
- step0: pc_rd, mem_load.
- step1: mem_rd while mem_ready=0. On mem_ready=1: ir<=bus_in, step<=0, state<=EXEC if the opcode is legal, else TRAP.

EXEC, general
- Runs the instruction's microsequence. step advances by one per cycle.
- A step asserting mem_rd or mem_wr holds until mem_ready=1.
- The last step asserts retire and either pc_inc or pc_wr, then state<=FETCH, step<=0.

EXEC, per-instruction sequences (terms: "imm->A" means bus_out=imm, bus_out_en, alu_wr, alu_op=0; "X op" means X on bus, alu_wr, alu_op as given)
- OP-IMM (0010011): imm_i->A; rs1 op {1, funct3[1:0]==01 ? funct7[5] : 0, funct3}; alu_rd, reg_wr rd, pc_inc.
- OP (0110011): rs2->A; rs1 op {1, funct7[5], funct3}; alu_rd, reg_wr rd, pc_inc.
- LUI (0110111): imm_u driven, reg_wr rd, pc_inc. Single step.
- AUIPC (0010111): imm_u->A; pc_rd add(10000); alu_rd, reg_wr rd, pc_inc.
- LW (0000011, funct3=010): imm_i->A; rs1 add; alu_rd, mem_load; mem_rd, reg_wr rd, pc_inc (stalling step).
- SW (0100011, funct3=010): imm_s->A; rs1 add; alu_rd, mem_load; rs2 reg_rd, mem_wr, pc_inc (stalling step).
- BRANCH (1100011), compare step:
  - rs2->A; rs1 compare.
  - BEQ/BNE use SUB (11000).
  - BLT/BGE use SLT (10010).
  - BLTU/BGEU use SLTU (10011).
- BRANCH, resolution:
  - alu_flag is sampled on step2.
  - taken = flag for BNE/BLT/BLTU, and !flag for BEQ/BGE/BGEU.
  - Not taken: step2 is final (pc_inc).
  - Taken: imm_b->A; pc_rd add; alu_rd, pc_wr.
  - Not-taken latency 3 EXEC cycles; taken 5.
- JAL (1101111): pc_rd->A; bus_out=4 add; alu_rd, reg_wr rd; imm_j->A; pc_rd add; alu_rd, pc_wr.
- JALR (1100111, funct3=000):
  - imm_i->A; rs1 add; alu_rd, tmp<=bus_in & ~1.
  - pc_rd->A; bus_out=4 add; alu_rd, reg_wr rd; bus_out=tmp, pc_wr.
  - Correct when rd==rs1.

Boundary conditions
- rd=0: writes are still issued; the register file discards them.
- Illegal opcode or funct3: enter TRAP. trap=1, all strobes 0, no PC change. Left only by reset.
- mem_ready stuck at 0: hold the current step indefinitely with strobes steady.
- Reset during a stall: abort immediately; no retire.
- The bus is driven by exactly one source per step. No step asserts bus_out_en together with any *_rd strobe.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - ALU op constants (LOAD_A, ADD, SUB, SLT, SLTU);
  - state enum;
  - immediate-extract functions imm_i, imm_s, imm_b, imm_u, imm_j.
- One sub-module, ctrl_decode: purely combinational; maps (ir, step, alu_flag) to the strobe bundle plus last/stall/illegal. control_seq keeps the FSM, step counter, ir and tmp.

Test Plan:
- ADDI x5,x0,-3: sequence imm->A, x0 op 10000, alu_rd+reg_wr addr 5. bus_out=0xFFFFFFFD in step0. retire after 3 EXEC cycles.
- LW x1,8(x2) with mem_ready low for 3 cycles on the load step: mem_rd and reg_wr held 4 cycles, then retire, pc_inc once.
- BEQ with alu_flag=1: not taken, pc_inc at step2, total 3 EXEC cycles. With alu_flag=0 and imm_b=-8: bus_out=0xFFFFFFF8 at step2, pc_wr at step4.
- JALR x3,x3,5 with x3=0x100 (bus_in=0x105 at the capture step): tmp=0x104, reg_wr addr 3 precedes the pc_wr step driving 0x104.
- ir=0xFFFFFFFF: trap=1 after fetch, no strobes for 20 cycles. rst_n pulse clears trap and restarts FETCH step0.
- rst_n low mid-SW stall: all outputs 0 asynchronously, no mem_wr or retire. After release, first cycle is pc_rd+mem_load.
